dcache_miss_ctrl: RTL and testbench

- Sequencing controller for the 4-way set-associative data cache.
- Accepts one load/store at a time from the core load-store unit and runs the tag lookup.
- On a hit, drives the LRU update. On a miss, selects the victim way from the LRU, writes back a dirty victim, refills the line from memory, updates tag and LRU, then replays the access.
- Sits between the LSU, the tag/data arrays, the LRU block and the memory bus.

---
 rtl/dcache_miss_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// Miss/hit sequencer for the 4-way data cache: lookup, victim writeback, refill, replay.
// Defining DCACHE_PERF_CNT_EN adds saturating hit_cnt_o/miss_cnt_o counters.
module dcache_miss_ctrl #(
  parameter int addr_width    = 32,
  parameter int block_size    = 16,
  parameter int associativity = 4
) (
  input  logic                                clock,
  input  logic                                rst,
  input  logic                                core_req_i,
  input  logic                                core_we_i,
  input  logic [addr_width-1:0]               core_addr_i,
  output logic                                core_gnt_o,
  output logic                                core_rvalid_o,
  input  logic                                tag_hit_i,
  input  logic [$clog2(associativity)-1:0]    hit_way_i,
  input  logic [$clog2(associativity)-1:0]    lru_way_i,
  input  logic                                victim_dirty_i,
  input  logic [addr_width-1:0]               victim_addr_i,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [addr_width-1:0]               mem_addr_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  output logic                                arr_we_o,
  output logic [$clog2(associativity)-1:0]    arr_way_o,
  output logic [$clog2(block_size/4)-1:0]     arr_word_o,
  output logic                                tag_we_o,
  output logic                                lru_hit_o,
  output logic                                lru_miss_o,
  output logic [$clog2(associativity)-1:0]    lru_way_o,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0]                         hit_cnt_o,
  output logic [31:0]                         miss_cnt_o,
`endif
  output logic                                busy_o
);

  localparam int WORDS = block_size / 4;
  localparam int WBITS = $clog2(WORDS);
  localparam int OBITS = $clog2(block_size);
  localparam int WAYB  = $clog2(associativity);
  localparam logic [WBITS:0] WORDS_N = (WBITS+1)'(WORDS);
  localparam logic [WBITS:0] LAST_N  = (WBITS+1)'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, WB, REFILL, UPDATE} state_t;

  state_t state, state_nxt;

  logic [addr_width-1:2] addr_q;
  logic                  we_q;
  logic                  replay_q;
  logic [WAYB-1:0]       vway_q;
  logic [addr_width-1:0] vaddr_q;
  logic [WBITS-1:0]      wcnt;
  logic [WBITS:0]        qcnt;
  logic [WBITS:0]        rcnt;

  logic take_req;
  logic lookup_hit;
  logic lookup_miss;
  logic wb_gnt;
  logic rf_gnt;
  logic rf_rsp;

  // Byte offset within a word never reaches the arrays or the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^core_addr_i[1:0];

  always_comb begin
    state_nxt     = state;
    core_gnt_o    = 1'b0;
    core_rvalid_o = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    arr_we_o      = 1'b0;
    arr_way_o     = '0;
    arr_word_o    = '0;
    tag_we_o      = 1'b0;
    lru_hit_o     = 1'b0;
    lru_miss_o    = 1'b0;
    lru_way_o     = '0;
    busy_o        = 1'b0;
    take_req      = 1'b0;
    lookup_hit    = 1'b0;
    lookup_miss   = 1'b0;
    wb_gnt        = 1'b0;
    rf_gnt        = 1'b0;
    rf_rsp        = 1'b0;
    if (!rst) begin
      busy_o = (state != IDLE);
      case (state)
        IDLE: begin
          core_gnt_o = core_req_i;
          take_req   = core_req_i;
          if (core_req_i) state_nxt = LOOKUP;
        end
        LOOKUP: begin
          if (tag_hit_i) begin
            // The replay after a refill is a hit by construction; only the miss is reported to the LRU.
            lookup_hit = 1'b1;
            lru_hit_o  = !replay_q;
            lru_way_o  = hit_way_i;
            arr_way_o  = hit_way_i;
            arr_word_o = addr_q[OBITS-1:2];
            arr_we_o   = we_q;
            state_nxt  = RESP;
          end else begin
            lookup_miss = 1'b1;
            state_nxt   = victim_dirty_i ? WB : REFILL;
          end
        end
        RESP: begin
          core_rvalid_o = 1'b1;
          state_nxt     = IDLE;
        end
        WB: begin
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = vaddr_q + addr_width'({wcnt, 2'b00});
          arr_way_o  = vway_q;
          arr_word_o = wcnt;
          wb_gnt     = mem_gnt_i;
          if (mem_gnt_i && (&wcnt)) state_nxt = REFILL;
        end
        REFILL: begin
          if (qcnt < WORDS_N) begin
            mem_req_o  = 1'b1;
            mem_addr_o = {addr_q[addr_width-1:OBITS], qcnt[WBITS-1:0], 2'b00};
            rf_gnt     = mem_gnt_i;
          end
          if (mem_rvalid_i && (rcnt < WORDS_N)) begin
            arr_we_o   = 1'b1;
            arr_way_o  = vway_q;
            arr_word_o = rcnt[WBITS-1:0];
            rf_rsp     = 1'b1;
            if (rcnt == LAST_N) state_nxt = UPDATE;
          end
        end
        UPDATE: begin
          tag_we_o   = 1'b1;
          lru_miss_o = 1'b1;
          lru_way_o  = vway_q;
          arr_way_o  = vway_q;
          state_nxt  = LOOKUP;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      replay_q <= 1'b0;
      vway_q   <= '0;
      vaddr_q  <= '0;
      wcnt     <= '0;
      qcnt     <= '0;
      rcnt     <= '0;
    end else begin
      state <= state_nxt;
      if (take_req) begin
        addr_q   <= core_addr_i[addr_width-1:2];
        we_q     <= core_we_i;
        replay_q <= 1'b0;
      end
      if (lookup_miss) begin
        vway_q  <= lru_way_i;
        vaddr_q <= victim_addr_i;
      end
      // wcnt wraps to zero on the last writeback grant.
      if (wb_gnt) wcnt <= wcnt + 1'b1;
      if (rf_gnt) qcnt <= qcnt + 1'b1;
      if (rf_rsp) rcnt <= rcnt + 1'b1;
      if (state == UPDATE) begin
        replay_q <= 1'b1;
        qcnt     <= '0;
        rcnt     <= '0;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (lookup_hit && !replay_q && (hit_cnt_o != 32'hFFFF_FFFF))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (lookup_miss && (miss_cnt_o != 32'hFFFF_FFFF))
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

  a_lru_excl: assert property (@(posedge clock) disable iff (rst) !(lru_hit_o && lru_miss_o));
  a_no_gnt_busy: assert property (@(posedge clock) disable iff (rst) busy_o |-> !core_gnt_o);

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized bench for dcache_miss_ctrl: per-access expected event lists from a line-level model.
module tb_dcache_miss_ctrl;
  localparam int AW    = 32;
  localparam int WORDS = 4;

  typedef int iq_t[$];

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          core_req_i = 1'b0;
  logic          core_we_i = 1'b0;
  logic [AW-1:0] core_addr_i = '0;
  logic          core_gnt_o, core_rvalid_o;
  logic          tag_hit_i = 1'b0;
  logic [1:0]    hit_way_i = '0;
  logic [1:0]    lru_way_i = '0;
  logic          victim_dirty_i = 1'b0;
  logic [AW-1:0] victim_addr_i = '0;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic          arr_we_o;
  logic [1:0]    arr_way_o;
  logic [1:0]    arr_word_o;
  logic          tag_we_o, lru_hit_o, lru_miss_o;
  logic [1:0]    lru_way_o;
  logic          busy_o;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  dcache_miss_ctrl dut (
    .clock(clock), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .tag_hit_i(tag_hit_i), .hit_way_i(hit_way_i), .lru_way_i(lru_way_i),
    .victim_dirty_i(victim_dirty_i), .victim_addr_i(victim_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .arr_we_o(arr_we_o), .arr_way_o(arr_way_o), .arr_word_o(arr_word_o),
    .tag_we_o(tag_we_o), .lru_hit_o(lru_hit_o), .lru_miss_o(lru_miss_o),
    .lru_way_o(lru_way_o),
`ifdef DCACHE_PERF_CNT_EN
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hits_m = 0;
  int misses_m = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input iq_t got, input iq_t exp);
    check({tag, "_n"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(tag, 64'(got[i]), 64'(exp[i]));
  endtask

  function automatic logic [63:0] outs_vec();
    return {17'd0, core_gnt_o, core_rvalid_o, mem_req_o, mem_we_o, mem_addr_o, arr_we_o,
            arr_way_o, arr_word_o, tag_we_o, lru_hit_o, lru_miss_o, lru_way_o, busy_o};
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Observed events, sampled mid-cycle.
  int  gnt_cnt, rv_cnt, gnt_cyc, rv_cyc;
  iq_t wb_q, rd_q, aw_q, tw_q, lh_q, lm_q;
  logic          hold_pend = 1'b0;
  logic [AW-1:0] hold_addr;
  logic          hold_we;

  initial forever begin
    @(negedge clock);
    #2;
    if (core_gnt_o) begin gnt_cnt++; gnt_cyc = cyc; end
    if (core_rvalid_o) begin rv_cnt++; rv_cyc = cyc; end
    if (mem_req_o && mem_gnt_i) begin
      if (mem_we_o) wb_q.push_back(int'(mem_addr_o));
      else rd_q.push_back(int'(mem_addr_o));
    end
    if (hold_pend && mem_req_o) begin
      check("mem_hold_addr", 64'(mem_addr_o), 64'(hold_addr));
      check("mem_hold_we", 64'(mem_we_o), 64'(hold_we));
    end
    hold_pend = mem_req_o && !mem_gnt_i;
    hold_addr = mem_addr_o;
    hold_we   = mem_we_o;
    if (arr_we_o) aw_q.push_back(int'({arr_way_o, arr_word_o}));
    if (tag_we_o) tw_q.push_back(int'(arr_way_o));
    if (lru_hit_o) lh_q.push_back(int'(lru_way_o));
    if (lru_miss_o) lm_q.push_back(int'(lru_way_o));
    if (lru_hit_o || lru_miss_o) check("lru_excl", 64'(lru_hit_o & lru_miss_o), 0);
  end

  // Memory and tag-array responder. Mode 0: zero wait, 1: random, 2: writes wait two cycles.
  int mem_mode = 0;
  int pend = 0;
  int wait_cnt = 0;

  initial forever begin
    @(negedge clock);
    #1;
    mem_rvalid_i = 1'b0;
    if (pend > 0 && (mem_mode == 0 || $urandom_range(0, 1) == 1)) begin
      mem_rvalid_i = 1'b1;
      pend--;
    end
    case (mem_mode)
      0: mem_gnt_i = 1'b1;
      1: mem_gnt_i = 1'($urandom_range(0, 1));
      default: begin
        if (mem_req_o && mem_we_o) begin
          if (wait_cnt == 2) begin mem_gnt_i = 1'b1; wait_cnt = 0; end
          else begin mem_gnt_i = 1'b0; wait_cnt++; end
        end else mem_gnt_i = 1'b1;
      end
    endcase
    if (mem_req_o && !mem_we_o && mem_gnt_i) pend++;
    // A tag write installs the line, so the following lookup hits in that way.
    if (tag_we_o) begin
      tag_hit_i = 1'b1;
      hit_way_i = arr_way_o;
    end
  end

  task automatic clear_obs();
    wb_q.delete(); rd_q.delete(); aw_q.delete();
    tw_q.delete(); lh_q.delete(); lm_q.delete();
    gnt_cnt = 0; rv_cnt = 0;
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input logic we, input logic hit,
                         input logic [1:0] hw, input logic [1:0] lw, input logic dirty,
                         input logic [AW-1:0] vaddr, input int mode, input logic hold);
    iq_t e_wb, e_rd, e_aw, e_tw, e_lh, e_lm;
    int word, lat;
    bit done;
    @(negedge clock);
    clear_obs();
    mem_mode = mode; wait_cnt = 0;
    tag_hit_i = hit; hit_way_i = hw; lru_way_i = lw;
    victim_dirty_i = dirty; victim_addr_i = vaddr;
    core_req_i = 1'b1; core_we_i = we; core_addr_i = addr;
    #3;
    check("gnt_idle", 64'(core_gnt_o), 1);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      core_req_i  = hold;
      core_addr_i = $urandom;
      core_we_i   = 1'($urandom_range(0, 1));
      #3;
      if (i == 0) check("busy_after_gnt", 64'(busy_o), 1);
      if (rv_cnt > 0) done = 1'b1;
    end
    core_req_i = 1'b0;
    check("rvalid_seen", 64'(done), 1);
    check("gnt_count", 64'(gnt_cnt), 1);
    check("rvalid_count", 64'(rv_cnt), 1);
    lat = rv_cyc - gnt_cyc;
    if (hit) check("hit_latency", 64'(lat), 2);
    else if (mode == 0) check("miss_latency", 64'(lat), 64'(dirty ? 2*WORDS+5 : WORDS+5));

    word = int'(addr[3:2]);
    if (hit) begin
      e_lh.push_back(int'(hw));
      if (we) e_aw.push_back(int'(hw)*4 + word);
      hits_m++;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (dirty) e_wb.push_back(int'(vaddr) + 4*i);
        e_rd.push_back(int'({addr[31:4], 4'h0}) + 4*i);
        e_aw.push_back(int'(lw)*4 + i);
      end
      if (we) e_aw.push_back(int'(lw)*4 + word);
      e_tw.push_back(int'(lw));
      e_lm.push_back(int'(lw));
      misses_m++;
    end
    cmp_q("mem_writes", wb_q, e_wb);
    cmp_q("mem_reads", rd_q, e_rd);
    cmp_q("arr_writes", aw_q, e_aw);
    cmp_q("tag_writes", tw_q, e_tw);
    cmp_q("lru_hits", lh_q, e_lh);
    cmp_q("lru_misses", lm_q, e_lm);
  endtask

  task automatic run_reset_mid_refill();
    bit seen;
    int aw_n;
    @(negedge clock);
    clear_obs();
    mem_mode = 0;
    tag_hit_i = 1'b0; lru_way_i = 2'd2; victim_dirty_i = 1'b0; victim_addr_i = 32'h0000_6000;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0000_3080;
    #3;
    check("rst_txn_gnt", 64'(core_gnt_o), 1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      core_req_i = 1'b0;
      #3;
      if (aw_q.size() >= 2) seen = 1'b1;
    end
    check("rst_two_responses", 64'(seen), 1);
    @(negedge clock);
    #3;
    rst = 1'b1;
    aw_n = aw_q.size();
    @(negedge clock);
    rst = 1'b0;
    #3;
    check("rst_outputs_zero", outs_vec(), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #3;
      check("rst_quiet", 64'({arr_we_o, mem_req_o, busy_o, core_rvalid_o, tag_we_o}), 0);
    end
    check("rst_pend_drained", 64'(pend), 0);
    check("rst_arr_write_count", 64'(aw_q.size()), 64'(aw_n));
    check("rst_no_rvalid", 64'(rv_cnt), 0);
    hits_m = 0;
    misses_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    rst = 1'b0;
    #3;
    check("reset_outputs", outs_vec(), 0);

    // Load hit, clean miss, dirty miss with slow writes, store hit.
    run_txn(32'h0000_1234, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(32'h0000_2040, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 32'h0000_7040, 0, 1'b1);
`ifdef DCACHE_PERF_CNT_EN
    check("hit_cnt_1", 64'(hit_cnt_o), 1);
    check("miss_cnt_1", 64'(miss_cnt_o), 1);
`endif
    run_txn(32'h0000_5044, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 32'h0000_8040, 2, 1'b0);
    run_txn(32'h0000_0A0C, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(32'h0000_9048, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 32'h0000_4010, 0, 1'b0);

    run_reset_mid_refill();

    for (int t = 0; t < 40; t++) begin
      run_txn($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom & 32'hFFFF_FFF0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

`ifdef DCACHE_PERF_CNT_EN
    check("hit_cnt_final", 64'(hit_cnt_o), 64'(hits_m));
    check("miss_cnt_final", 64'(miss_cnt_o), 64'(misses_m));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
